// File: rtl/sum_result_buffer_pkg.sv
// sum_result_buffer_pkg: widths, result-entry layout and mean rounding shared by the result buffer.
package sum_result_buffer_pkg;

    localparam int SUM_W      = 17;
    localparam int MEAN_W     = 8;
    localparam int LOG2_N     = 7;
    localparam int SEQ_W      = 4;
    localparam int ROUND_BIAS = 64;
    localparam int ENTRY_W    = SUM_W + MEAN_W + 1 + SEQ_W;

    typedef struct packed {
        logic [SUM_W-1:0]  sum;
        logic [MEAN_W-1:0] mean;
        logic              over;
        logic [SEQ_W-1:0]  seq;
    } result_t;

    // Round-half-up divide by 128, one bit wider than the sum so the bias cannot overflow.
    function automatic logic [MEAN_W-1:0] calc_mean(input logic [SUM_W-1:0] s);
        logic [SUM_W:0] b;
        b = ({1'b0, s} + (SUM_W+1)'(ROUND_BIAS)) >> LOG2_N;
        return (b > (SUM_W+1)'(255)) ? '1 : b[MEAN_W-1:0];
    endfunction

endpackage

// File: rtl/sum_result_fifo.sv
// sum_result_fifo: first-word-fall-through FIFO with occupancy; holds the last popped word while empty.
module sum_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 30
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_din,
    output logic [W-1:0]               o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_prev_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_level    = r_wr - r_rd;
    assign o_empty    = (r_wr == r_rd);
    assign o_full     = (o_level == (AW+1)'(DEPTH));
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);
    assign w_rd_idx   = r_rd[AW-1:0];
    assign w_prev_idx = w_rd_idx - AW'(1);
    // The slot behind the read pointer is the last word popped and is not rewritten until the FIFO refills.
    assign o_dout     = o_empty ? r_mem[w_prev_idx] : r_mem[w_rd_idx];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr[AW-1:0]] <= i_din;
                r_wr <= r_wr + (AW+1)'(1);
            end
            if (w_do_pop) r_rd <= r_rd + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/sum_result_buffer.sv
// sum_result_buffer: captures block sums, derives rounded mean/over flag/sequence tag,
// and queues results to a valid/ready consumer with drop accounting.
module sum_result_buffer
    import sum_result_buffer_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [7:0]  THRESHOLD = 8'd200
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic [SUM_W-1:0]        in_sum,
    input  logic                    in_valid,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SUM_W-1:0]        out_sum,
    output logic [MEAN_W-1:0]       out_mean,
    output logic                    out_over,
    output logic [SEQ_W-1:0]        out_seq,
    output logic                    overflow,
    output logic [7:0]              drop_count,
    output logic [$clog2(DEPTH):0]  level
);

    logic              r_pipe_vld;
    logic [SUM_W-1:0]  r_pipe_sum;
    logic [SEQ_W-1:0]  r_pipe_seq;
    logic [SEQ_W-1:0]  r_seq;
    logic              r_overflow;
    logic [7:0]        r_drop_count;
    logic [MEAN_W-1:0] w_mean;
    result_t           w_push_entry;
    result_t           w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_drop;

    assign w_mean       = calc_mean(r_pipe_sum);
    assign w_push_entry = '{sum: r_pipe_sum, mean: w_mean, over: (w_mean > THRESHOLD), seq: r_pipe_seq};
    assign w_pop        = !w_empty && out_ready;
    assign w_drop       = r_pipe_vld && w_full && !w_pop;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_pipe_vld   <= 1'b0;
            r_pipe_sum   <= '0;
            r_pipe_seq   <= '0;
            r_seq        <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_pipe_vld <= in_valid;
            if (in_valid) begin
                r_pipe_sum <= in_sum;
                r_pipe_seq <= r_seq;
            end
            r_seq        <= clear ? '0 : r_seq + SEQ_W'(in_valid);
            r_overflow   <= !clear && (r_overflow || w_drop);
            r_drop_count <= clear ? '0 : (w_drop && r_drop_count != 8'hFF) ? r_drop_count + 8'd1 : r_drop_count;
        end
    end

    sum_result_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .i_push  (r_pipe_vld),
        .i_pop   (out_ready),
        .i_din   (w_push_entry),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign out_valid  = !w_empty;
    assign out_sum    = w_head.sum;
    assign out_mean   = w_head.mean;
    assign out_over   = w_head.over;
    assign out_seq    = w_head.seq;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_sum_result_buffer.sv
// tb_sum_result_buffer: directed scenario tasks with hand-computed expectations for sum_result_buffer.
module tb_sum_result_buffer;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic [16:0] in_sum = '0;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [16:0] out_sum;
    logic [7:0]  out_mean;
    logic        out_over;
    logic [3:0]  out_seq;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [2:0]  level;

    int n_vec = 0;
    int n_err = 0;

    sum_result_buffer #(.DEPTH(4), .THRESHOLD(8'd200)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .in_sum     (in_sum),
        .in_valid   (in_valid),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_mean   (out_mean),
        .out_over   (out_over),
        .out_seq    (out_seq),
        .overflow   (overflow),
        .drop_count (drop_count),
        .level      (level)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        step();
        step();
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0d want 0", out_valid); end n_vec++;
        if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end n_vec++;
        if ({out_sum, out_mean, out_over, out_seq} !== 30'd0) begin n_err++; $display("FAIL reset_data got %h want 0", {out_sum, out_mean, out_over, out_seq}); end n_vec++;
        if ({overflow, drop_count} !== 9'd0) begin n_err++; $display("FAIL reset_ovf got %0d/%0d want 0/0", overflow, drop_count); end n_vec++;
        RST_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        do_clear();
        in_sum = 17'd12800;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early got %0d want 0", out_valid); end n_vec++;
        step();
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0d want 1", out_valid); end n_vec++;
        if ({out_sum, out_mean, out_over, out_seq} !== {17'd12800, 8'd100, 1'b0, 4'd0})
            begin n_err++; $display("FAIL single_head got sum=%0d mean=%0d over=%0d seq=%0d want 12800/100/0/0", out_sum, out_mean, out_over, out_seq); end n_vec++;
        step();
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_hold got %0d want 1", out_valid); end n_vec++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop got %0d want 0", out_valid); end n_vec++;
        if (out_sum !== 17'd12800) begin n_err++; $display("FAIL single_empty_hold got %0d want 12800", out_sum); end n_vec++;
    endtask

    // Back-to-back pulses with the consumer always ready: each entry is head for exactly one cycle.
    task automatic test_rounding();
        logic [16:0] t_sum [6] = '{17'd12863, 17'd12864, 17'd32640, 17'd25663, 17'd25664, 17'h1FFFF};
        logic [7:0]  t_mean[6] = '{8'd100, 8'd101, 8'd255, 8'd200, 8'd201, 8'd255};
        logic        t_over[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        do_clear();
        out_ready = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            in_valid = (k < 6);
            in_sum = (k < 6) ? t_sum[k] : 17'd0;
            step();
            if (k >= 1) begin
                if ({out_valid, out_sum, out_mean, out_over, out_seq} !== {1'b1, t_sum[k-1], t_mean[k-1], t_over[k-1], 4'(k-1)})
                    begin n_err++; $display("FAIL round[%0d] got v=%0d sum=%0d mean=%0d over=%0d seq=%0d want 1/%0d/%0d/%0d/%0d", k-1, out_valid, out_sum, out_mean, out_over, out_seq, t_sum[k-1], t_mean[k-1], t_over[k-1], k-1); end
                n_vec++;
            end
        end
        step();
        out_ready = 1'b0;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL round_drain got %0d want 0", out_valid); end n_vec++;
    endtask

    task automatic test_overflow();
        do_clear();
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_sum = 17'(100 * k);
            step();
        end
        in_valid = 1'b0;
        step();
        if (level !== 3'd4) begin n_err++; $display("FAIL ovf_level got %0d want 4", level); end n_vec++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0d want 1", overflow); end n_vec++;
        if (drop_count !== 8'd2) begin n_err++; $display("FAIL ovf_drops got %0d want 2", drop_count); end n_vec++;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if ({out_valid, out_seq, out_sum} !== {1'b1, 4'(k), 17'(100 * k)})
                begin n_err++; $display("FAIL ovf_drain[%0d] got v=%0d seq=%0d sum=%0d want 1/%0d/%0d", k, out_valid, out_seq, out_sum, k, 100 * k); end
            n_vec++;
            step();
        end
        out_ready = 1'b0;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %0d want 0", out_valid); end n_vec++;
        in_valid = 1'b1;
        clear = 1'b1;
        in_sum = 17'd640;
        step();
        in_valid = 1'b0;
        clear = 1'b0;
        if ({overflow, drop_count} !== 9'd0) begin n_err++; $display("FAIL ovf_clear got %0d/%0d want 0/0", overflow, drop_count); end n_vec++;
        step();
        if ({out_valid, out_seq, out_mean} !== {1'b1, 4'd6, 8'd5}) begin n_err++; $display("FAIL ovf_seq6 got v=%0d seq=%0d mean=%0d want 1/6/5", out_valid, out_seq, out_mean); end n_vec++;
        out_ready = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        step();
        if ({out_valid, out_seq} !== {1'b1, 4'd0}) begin n_err++; $display("FAIL ovf_seq_after_clear got v=%0d seq=%0d want 1/0", out_valid, out_seq); end n_vec++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_clear();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_sum = 17'(1000 + k);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if ({level, drop_count, overflow} !== {3'd4, 8'd0, 1'b0}) begin n_err++; $display("FAIL pp_full got level=%0d drops=%0d ovf=%0d want 4/0/0", level, drop_count, overflow); end n_vec++;
        if (out_seq !== 4'd1) begin n_err++; $display("FAIL pp_head got %0d want 1", out_seq); end n_vec++;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        if ({drop_count, overflow} !== {8'd1, 1'b1}) begin n_err++; $display("FAIL pp_drop got %0d/%0d want 1/1", drop_count, overflow); end n_vec++;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        if ({drop_count, overflow, level} !== {8'd0, 1'b0, 3'd4}) begin n_err++; $display("FAIL pp_clear_drop got drops=%0d ovf=%0d level=%0d want 0/0/4", drop_count, overflow, level); end n_vec++;
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if ({out_seq, out_sum} !== {4'(k), 17'(1000 + k)}) begin n_err++; $display("FAIL pp_drain[%0d] got seq=%0d sum=%0d want %0d/%0d", k, out_seq, out_sum, k, 1000 + k); end n_vec++;
            step();
        end
        out_ready = 1'b0;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL pp_empty got %0d want 0", out_valid); end n_vec++;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_sum = 17'd5000;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        in_sum = 17'd6000;
        step();
        in_valid = 1'b0;
        RST_n = 1'b0;
        #1;
        if ({out_valid, level} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL mid_reset got v=%0d level=%0d want 0/0", out_valid, level); end n_vec++;
        step();
        RST_n = 1'b1;
        step();
        step();
        step();
        if ({out_valid, level, out_sum} !== {1'b0, 3'd0, 17'd0}) begin n_err++; $display("FAIL mid_release got v=%0d level=%0d sum=%0d want 0/0/0", out_valid, level, out_sum); end n_vec++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rounding();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
